ir_cmd_sequencer: RTL and testbench

- Sits downstream of the IR beacon frequency detector. Consumes its per-edge done strobe and 3-bit classification.
- Requires CONFIRM_N consecutive identical non-NONE classifications before issuing a command to navigation over a valid/ready handshake.
- Enforces a post-command lockout and flags loss of beacon via a watchdog.

---
 rtl/ir_pkg.sv | 26 ++
 rtl/ir_cycle_timer.sv | 33 +++
 rtl/ir_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_ir_cmd_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared IR beacon definitions: detector decision codes, sequencer states and small helpers.
package ir_pkg;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] R_B  = 3'd1;
    localparam logic [2:0] R_G  = 3'd2;
    localparam logic [2:0] B_G  = 3'd3;
    localparam logic [2:0] STOP = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        ISSUE   = 2'd2,
        HOLD    = 2'd3
    } seq_state_e;

    // Codes above STOP are not produced by a healthy detector; fold them into NONE.
    function automatic logic [2:0] sanitize_code(input logic [2:0] code);
        return (code > STOP) ? NONE : code;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ir_cycle_timer.sv
// Saturating cycle counter with clear/load; expired while the count is at or above LIMIT.
module ir_cycle_timer #(
    parameter int W     = 21,
    parameter int LIMIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         expired
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt < LIMIT_W)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt >= LIMIT_W);

endmodule

// File: rtl/ir_cmd_sequencer.sv
// Confirms repeated IR beacon classifications and hands one command at a time to navigation.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a non-NONE sample
// CONFIRM | counting consecutive identical samples of the candidate
// ISSUE   | cmd_valid high, waiting for cmd_ready
// HOLD    | post-command lockout, samples ignored
module ir_cmd_sequencer
    import ir_pkg::*;
#(
    parameter int CONFIRM_N   = 4,
    parameter int TIMEOUT_CYC = 1200000,
    parameter int HOLD_CYC    = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       det_done,
    input  logic [2:0] det_decision,
    input  logic       enable,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [2:0] active_code,
    output logic       signal_lost,
    output logic       busy
);

    localparam int         TW        = $clog2(max_int(TIMEOUT_CYC, HOLD_CYC) + 1);
    localparam logic [3:0] CONFIRM_W = 4'(CONFIRM_N);

    seq_state_e state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] cand, cand_nxt;
    logic [2:0] active, active_nxt;
    logic       done_q;
    logic       sample;
    logic [2:0] samp_code;
    logic       wd_expired;
    logic       hold_expired;
    logic       hold_load;

    // The detector's decision settles one cycle after its done strobe.
    assign sample    = done_q & enable;
    assign samp_code = sanitize_code(det_decision);

    ir_cycle_timer #(
        .W     (TW),
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (det_done),
        .load     (1'b0),
        .load_val ('0),
        .count    (1'b1),
        .expired  (wd_expired)
    );

    // Loaded with 1 on the handshake so HOLD lasts exactly HOLD_CYC cycles.
    ir_cycle_timer #(
        .W     (TW),
        .LIMIT (HOLD_CYC)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (1'b0),
        .load     (hold_load),
        .load_val (TW'(1)),
        .count    (state == HOLD),
        .expired  (hold_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            cand   <= NONE;
            active <= NONE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            cand   <= cand_nxt;
            active <= active_nxt;
            done_q <= det_done;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cand_nxt   = cand;
        active_nxt = active;
        hold_load  = 1'b0;
        case (state)
            IDLE: begin
                if (!enable) begin
                    cnt_nxt = '0;
                end else if (sample && (samp_code != NONE)) begin
                    cand_nxt  = samp_code;
                    cnt_nxt   = 4'd1;
                    state_nxt = CONFIRM;
                end
            end
            CONFIRM: begin
                if (!enable || wd_expired) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (sample) begin
                    if (samp_code == NONE) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else if (samp_code == cand) begin
                        cnt_nxt = cnt + 4'd1;
                    end else begin
                        cand_nxt = samp_code;
                        cnt_nxt  = 4'd1;
                    end
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    active_nxt = cand;
                    hold_load  = 1'b1;
                    state_nxt  = enable ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!enable || hold_expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Confirm decision, shared by IDLE (CONFIRM_N of 1) and CONFIRM.
        if ((state_nxt == CONFIRM) && (cnt_nxt >= CONFIRM_W)) begin
            cnt_nxt   = '0;
            state_nxt = ((cand_nxt == active) && (cand_nxt != STOP)) ? IDLE : ISSUE;
        end
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_code  = NONE;
        busy      = (state != IDLE);
        if (state == ISSUE) begin
            cmd_valid = 1'b1;
            cmd_code  = cand;
        end
    end

    assign active_code = active;
    assign signal_lost = wd_expired;

endmodule

// File: tb/tb_ir_cmd_sequencer.sv
// Self-checking bench for ir_cmd_sequencer: directed corner sequences, a vector table and
// randomized samples checked against a run-length reference model.
module tb_ir_cmd_sequencer;
    import ir_pkg::*;

    localparam int CN = 3;
    localparam int TO = 1000;
    localparam int HC = 500;

    logic       clk;
    logic       rst_n;
    logic       det_done;
    logic [2:0] det_decision;
    logic       enable;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [2:0] active_code;
    logic       signal_lost;
    logic       busy;

    int         checks;
    int         errors;
    int         xfers;
    logic [2:0] last_code;

    typedef struct packed {
        logic [3:0][2:0] s;
        logic            exp_issue;
        logic [2:0]      exp_code;
    } vec_t;

    vec_t tbl [8];

    ir_cmd_sequencer #(
        .CONFIRM_N   (CN),
        .TIMEOUT_CYC (TO),
        .HOLD_CYC    (HC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .det_done     (det_done),
        .det_decision (det_decision),
        .enable       (enable),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .active_code  (active_code),
        .signal_lost  (signal_lost),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            xfers     = xfers + 1;
            last_code = cmd_code;
        end
    end

    initial begin
        #1000000;
        $display("FAIL time_limit: simulation did not finish, got timeout required finish");
        $fatal(1, "time limit");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b required %0b", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        det_done  = 1'b0;
        cmd_ready = 1'b0;
        enable    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Detector model: done pulse, decision valid on the following cycle.
    task automatic do_sample(input logic [2:0] code);
        det_decision = 3'($urandom_range(0, 7));
        det_done     = 1'b1;
        @(negedge clk);
        det_done     = 1'b0;
        det_decision = code;
        @(negedge clk);
    endtask

    // Called at the negedge right after the handshake edge.
    task automatic wait_hold(input string name);
        repeat (HC - 1) @(negedge clk);
        chk1({name, "_hold_busy"}, busy, 1'b1);
        @(negedge clk);
        chk1({name, "_hold_done"}, busy, 1'b0);
    endtask

    task automatic run_confirm(input logic [2:0] code, input int gap, input logic exp_issue,
                               input string name);
        for (int k = 0; k < CN; k++) begin
            do_sample(code);
            if (k < CN - 1) repeat (gap) @(negedge clk);
        end
        chk1({name, "_valid"}, cmd_valid, exp_issue);
        if (exp_issue) begin
            chk3({name, "_code"}, cmd_code, code);
            @(negedge clk);
            chk1({name, "_valid_drop"}, cmd_valid, 1'b0);
            chk3({name, "_active"}, active_code, code);
            wait_hold(name);
        end else begin
            @(negedge clk);
            chk1({name, "_busy"}, busy, 1'b0);
            chk1({name, "_valid_late"}, cmd_valid, 1'b0);
        end
    endtask

    int         x0;
    int         exp_x;
    int         d;
    int         nign;
    logic       stable_ok;
    logic       issue;
    logic [2:0] code;
    logic [2:0] code_s;
    logic [2:0] prev;
    logic [2:0] m_active;
    logic [2:0] run_code;
    int         run_len;

    initial begin
        checks       = 0;
        errors       = 0;
        xfers        = 0;
        last_code    = NONE;
        det_done     = 1'b0;
        det_decision = NONE;
        enable       = 1'b1;
        cmd_ready    = 1'b0;
        rst_n        = 1'b0;

        tbl[0] = '{s: {NONE, R_G, R_G, R_G},     exp_issue: 1'b1, exp_code: R_G};
        tbl[1] = '{s: {B_G, B_G, R_B, R_B},      exp_issue: 1'b0, exp_code: NONE};
        tbl[2] = '{s: {R_B, R_B, NONE, R_B},     exp_issue: 1'b0, exp_code: NONE};
        tbl[3] = '{s: {R_G, STOP, STOP, STOP},   exp_issue: 1'b1, exp_code: STOP};
        tbl[4] = '{s: {3'd5, 3'd5, 3'd5, 3'd5},  exp_issue: 1'b0, exp_code: NONE};
        tbl[5] = '{s: {B_G, B_G, 3'd6, B_G},     exp_issue: 1'b0, exp_code: NONE};
        tbl[6] = '{s: {B_G, B_G, B_G, R_B},      exp_issue: 1'b1, exp_code: B_G};
        tbl[7] = '{s: {R_B, R_B, R_B, 3'd7},     exp_issue: 1'b1, exp_code: R_B};

        repeat (3) @(negedge clk);
        chk1("rst_valid", cmd_valid, 1'b0);
        chk3("rst_code", cmd_code, NONE);
        chk3("rst_active", active_code, NONE);
        chk1("rst_lost", signal_lost, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three R_G at 100-cycle spacing, ready tied high.
        cmd_ready = 1'b1;
        run_confirm(R_G, 100, 1'b1, "a");

        // Candidate restarts when the code changes.
        x0 = xfers;
        do_sample(R_B); repeat (10) @(negedge clk);
        do_sample(R_B); repeat (10) @(negedge clk);
        do_sample(B_G); repeat (10) @(negedge clk);
        do_sample(B_G); repeat (10) @(negedge clk);
        chk1("b_no_early", cmd_valid, 1'b0);
        do_sample(B_G);
        chk1("b_valid", cmd_valid, 1'b1);
        chk3("b_code", cmd_code, B_G);
        @(negedge clk);
        wait_hold("b");
        chkn("b_xfers", xfers - x0, 1);
        chk3("b_last_code", last_code, B_G);

        // Back-pressure with samples and a watchdog expiry while offering.
        cmd_ready = 1'b0;
        x0 = xfers;
        do_sample(R_B); repeat (10) @(negedge clk);
        do_sample(R_B); repeat (10) @(negedge clk);
        do_sample(R_B);
        stable_ok = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            det_done     = (i == 20) || (i == 40);
            det_decision = ((i == 21) || (i == 41)) ? R_G : 3'($urandom_range(0, 7));
            if ((cmd_valid !== 1'b1) || (cmd_code !== R_B)) stable_ok = 1'b0;
            @(negedge clk);
        end
        det_done = 1'b0;
        chk1("c_stable", stable_ok, 1'b1);
        chk1("c_lost", signal_lost, 1'b1);
        chk1("c_busy", busy, 1'b1);
        chkn("c_no_xfer", xfers - x0, 0);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chkn("c_xfer", xfers - x0, 1);
        chk3("c_last_code", last_code, R_B);
        chk1("c_valid_drop", cmd_valid, 1'b0);
        chk3("c_active", active_code, R_B);
        wait_hold("c");

        // Duplicate suppression, STOP always reissued.
        cmd_ready = 1'b1;
        run_confirm(R_G, 10, 1'b1, "d1");
        x0 = xfers;
        run_confirm(R_G, 10, 1'b0, "d2");
        chkn("d2_xfers", xfers - x0, 0);
        run_confirm(STOP, 10, 1'b1, "d3");
        run_confirm(STOP, 10, 1'b1, "d4");

        // Watchdog expiry in CONFIRM.
        x0 = xfers;
        do_sample(R_B); repeat (10) @(negedge clk);
        do_sample(R_B);
        repeat (TO - 2) @(negedge clk);
        chk1("e_lost_early", signal_lost, 1'b0);
        chk1("e_busy_confirm", busy, 1'b1);
        @(negedge clk);
        chk1("e_lost", signal_lost, 1'b1);
        @(negedge clk);
        chk1("e_busy_idle", busy, 1'b0);
        det_decision = 3'($urandom_range(0, 7));
        det_done     = 1'b1;
        chk1("e_lost_hold", signal_lost, 1'b1);
        @(negedge clk);
        chk1("e_lost_clear", signal_lost, 1'b0);
        det_done     = 1'b0;
        det_decision = R_B;
        @(negedge clk);
        chk1("e_restart", busy, 1'b1);
        repeat (5) @(negedge clk);
        do_sample(R_B);
        chk1("e_cnt_two", cmd_valid, 1'b0);
        repeat (5) @(negedge clk);
        do_sample(R_B);
        chk1("e_valid", cmd_valid, 1'b1);
        chk3("e_code", cmd_code, R_B);
        @(negedge clk);
        wait_hold("e");
        chkn("e_xfers", xfers - x0, 1);

        // Reset while offering a command.
        cmd_ready = 1'b0;
        do_sample(R_G); repeat (5) @(negedge clk);
        do_sample(R_G); repeat (5) @(negedge clk);
        do_sample(R_G);
        chk1("f_valid", cmd_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("f_valid_rst", cmd_valid, 1'b0);
        chk3("f_code_rst", cmd_code, NONE);
        chk3("f_active_rst", active_code, NONE);
        chk1("f_busy_rst", busy, 1'b0);
        chk1("f_lost_rst", signal_lost, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // enable low during CONFIRM discards the partial count.
        x0 = xfers;
        do_sample(R_B); repeat (5) @(negedge clk);
        do_sample(R_B);
        chk1("g_confirm", busy, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("g_idle", busy, 1'b0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        do_sample(R_B);
        chk1("g_restart", busy, 1'b1);
        repeat (5) @(negedge clk);
        do_sample(R_B);
        chk1("g_no_cmd", cmd_valid, 1'b0);
        chkn("g_xfers", xfers - x0, 0);
        do_sample(NONE);
        chk1("g_none_idle", busy, 1'b0);

        // Vector table, fresh reset per row.
        for (int r = 0; r < 8; r++) begin
            reset_dut();
            cmd_ready = 1'b1;
            x0 = xfers;
            for (int k = 0; k < 4; k++) begin
                do_sample(tbl[r].s[k]);
                repeat (10) @(negedge clk);
            end
            chkn($sformatf("tbl%0d_xfers", r), xfers - x0, int'(tbl[r].exp_issue));
            chk3($sformatf("tbl%0d_active", r), active_code,
                 tbl[r].exp_issue ? tbl[r].exp_code : NONE);
            if (tbl[r].exp_issue) chk3($sformatf("tbl%0d_code", r), last_code, tbl[r].exp_code);
        end

        // Randomized samples against a run-length model.
        reset_dut();
        m_active = NONE;
        run_code = NONE;
        run_len  = 0;
        exp_x    = 0;
        x0       = xfers;
        prev     = 3'($urandom_range(1, 4));
        for (int n = 0; n < 300; n++) begin
            code   = ($urandom_range(0, 99) < 70) ? prev : 3'($urandom_range(0, 7));
            prev   = code;
            code_s = (code > STOP) ? NONE : code;
            if (code_s == NONE) begin
                run_len = 0;
            end else if ((run_len > 0) && (code_s == run_code)) begin
                run_len++;
            end else begin
                run_code = code_s;
                run_len  = 1;
            end
            issue = 1'b0;
            if (run_len == CN) begin
                run_len = 0;
                issue   = !((run_code == m_active) && (run_code != STOP));
            end
            do_sample(code);
            chk1("rnd_valid", cmd_valid, issue);
            if (issue) begin
                chk3("rnd_code", cmd_code, run_code);
                d = $urandom_range(0, 4);
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    chk1("rnd_valid_wait", cmd_valid, 1'b1);
                end
                cmd_ready = 1'b1;
                @(negedge clk);
                cmd_ready = 1'b0;
                m_active  = run_code;
                exp_x++;
                chk1("rnd_valid_drop", cmd_valid, 1'b0);
                chk3("rnd_active", active_code, m_active);
                nign = $urandom_range(0, 3);
                for (int i = 0; i < nign; i++) begin
                    do_sample(3'($urandom_range(1, 4)));
                    repeat (5) @(negedge clk);
                end
                repeat (HC - 1 - 7 * nign) @(negedge clk);
                chk1("rnd_hold_busy", busy, 1'b1);
                @(negedge clk);
                chk1("rnd_hold_done", busy, 1'b0);
            end else begin
                repeat ($urandom_range(1, 25)) @(negedge clk);
            end
        end
        chkn("rnd_xfers", xfers - x0, exp_x);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
